// File: rtl/fu2_pkg.sv
// Shared widths, select encodings and flag bit positions for the fu2 issue/writeback slice.
package fu2_pkg;
  localparam int DSIZE  = 64;
  localparam int OPSIZE = 5;
  localparam int ASIZE  = 6;
  localparam int RSIZE  = 3;

  localparam logic SEL_DP2 = 1'b0;
  localparam logic SEL_SHF = 1'b1;

  localparam int FLAG_Z = 3;
  localparam int FLAG_R = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_N = 0;
endpackage

// File: rtl/fu2_regfile.sv
// Register file: four combinational reads, one synchronous write, register 0 hardwired to zero.
module fu2_regfile #(
  parameter int DSIZE = 64,
  parameter int RSIZE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RSIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [RSIZE-1:0] raddr_a,
  input  logic [RSIZE-1:0] raddr_b,
  input  logic [RSIZE-1:0] raddr_c,
  input  logic [RSIZE-1:0] raddr_d,
  output logic [DSIZE-1:0] rdata_a,
  output logic [DSIZE-1:0] rdata_b,
  output logic [DSIZE-1:0] rdata_c,
  output logic [DSIZE-1:0] rdata_d
);
  localparam int NREG = 2 ** RSIZE;

  logic [DSIZE-1:0] regs_q [NREG];
  logic [DSIZE-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign rdata_c = regs_q[raddr_c];
  assign rdata_d = regs_q[raddr_d];
endmodule

// File: rtl/fu2_issue.sv
// Issue and writeback stage for fu2: RAW interlock on the S1 slot, FU_OUT forwarding from S2.
module fu2_issue
  import fu2_pkg::*;
#(
  parameter int DSIZE  = fu2_pkg::DSIZE,
  parameter int OPSIZE = fu2_pkg::OPSIZE,
  parameter int ASIZE  = fu2_pkg::ASIZE,
  parameter int RSIZE  = fu2_pkg::RSIZE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [RSIZE-1:0]  IN_RA,
  input  logic [RSIZE-1:0]  IN_RB,
  input  logic [RSIZE-1:0]  IN_RC,
  input  logic [RSIZE-1:0]  IN_RD,
  input  logic [RSIZE-1:0]  IN_RW,
  input  logic              IN_WE,
  input  logic [OPSIZE-1:0] IN_OP1,
  input  logic [OPSIZE-1:0] IN_OP2,
  input  logic [ASIZE-1:0]  IN_SHF_AMT,
  input  logic [1:0]        IN_SHF_MODE,
  input  logic              IN_SEL,
  output logic [DSIZE-1:0]  A,
  output logic [DSIZE-1:0]  B,
  output logic [DSIZE-1:0]  C,
  output logic [DSIZE-1:0]  D,
  output logic [OPSIZE-1:0] OP1,
  output logic [OPSIZE-1:0] OP2,
  output logic [ASIZE-1:0]  SHF_AMT,
  output logic [1:0]        SHF_MODE,
  output logic              SEL,
  input  logic [DSIZE-1:0]  FU_OUT,
  input  logic              FU_Z,
  input  logic              FU_R,
  input  logic              FU_O,
  input  logic              FU_N,
  output logic [3:0]        FLAGS,
  output logic              WB_VALID,
  output logic [RSIZE-1:0]  WB_ADDR,
  output logic [DSIZE-1:0]  WB_DATA
);
  logic [DSIZE-1:0]  a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic [OPSIZE-1:0] op1_q, op2_q, op1_d, op2_d;
  logic [ASIZE-1:0]  shf_amt_q, shf_amt_d;
  logic [1:0]        shf_mode_q, shf_mode_d;
  logic              sel_q, sel_d;
  logic              s1_valid_q, s1_valid_d, s1_we_q, s1_we_d;
  logic [RSIZE-1:0]  s1_rw_q, s1_rw_d;
  logic              s2_valid_q, s2_valid_d, s2_we_q, s2_we_d;
  logic [RSIZE-1:0]  s2_rw_q, s2_rw_d;
  logic [3:0]        flags_q, flags_d;

  logic [DSIZE-1:0]  rf_a, rf_b, rf_c, rf_d;
  logic              wb_valid, s1_blocks, stall, in_ready, accept;

  fu2_regfile #(.DSIZE(DSIZE), .RSIZE(RSIZE)) u_rf (
    .clk(CLK), .rst(RST), .we(wb_valid), .waddr(s2_rw_q), .wdata(FU_OUT),
    .raddr_a(IN_RA), .raddr_b(IN_RB), .raddr_c(IN_RC), .raddr_d(IN_RD),
    .rdata_a(rf_a), .rdata_b(rf_b), .rdata_c(rf_c), .rdata_d(rf_d)
  );

  // S2 result beats the RF so a same-cycle write and read sees the new value.
  function automatic logic [DSIZE-1:0] pick(input logic [RSIZE-1:0] addr,
                                            input logic [DSIZE-1:0] rf_val,
                                            input logic             fwd_en,
                                            input logic [RSIZE-1:0] fwd_addr,
                                            input logic [DSIZE-1:0] fwd_val);
    if (addr == '0)                         return '0;
    else if (fwd_en && (addr == fwd_addr))  return fwd_val;
    else                                    return rf_val;
  endfunction

  always_comb begin
    wb_valid  = s2_valid_q && s2_we_q && (s2_rw_q != '0);
    s1_blocks = s1_valid_q && s1_we_q && (s1_rw_q != '0);
    // Only the sources the selected datapath consumes can stall.
    if (IN_SEL == SEL_SHF) stall = s1_blocks && ((IN_RA == s1_rw_q) || (IN_RB == s1_rw_q));
    else                   stall = s1_blocks && ((IN_RC == s1_rw_q) || (IN_RD == s1_rw_q));
    in_ready = !RST && !stall;
    accept   = IN_VALID && in_ready;

    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    op1_d = op1_q; op2_d = op2_q; shf_amt_d = shf_amt_q; shf_mode_d = shf_mode_q; sel_d = sel_q;
    s1_rw_d = s1_rw_q; s1_we_d = s1_we_q;
    if (accept) begin
      a_d        = pick(IN_RA, rf_a, wb_valid, s2_rw_q, FU_OUT);
      b_d        = pick(IN_RB, rf_b, wb_valid, s2_rw_q, FU_OUT);
      c_d        = pick(IN_RC, rf_c, wb_valid, s2_rw_q, FU_OUT);
      d_d        = pick(IN_RD, rf_d, wb_valid, s2_rw_q, FU_OUT);
      op1_d      = IN_OP1;
      op2_d      = IN_OP2;
      shf_amt_d  = IN_SHF_AMT;
      shf_mode_d = IN_SHF_MODE;
      sel_d      = IN_SEL;
      s1_rw_d    = IN_RW;
      s1_we_d    = IN_WE;
    end
    s1_valid_d = accept;
    s2_valid_d = s1_valid_q;
    s2_rw_d    = s1_rw_q;
    s2_we_d    = s1_we_q;

    flags_d = flags_q;
    if (s2_valid_q) begin
      flags_d[FLAG_Z] = FU_Z;
      flags_d[FLAG_R] = FU_R;
      flags_d[FLAG_O] = FU_O;
      flags_d[FLAG_N] = FU_N;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      op1_q <= '0; op2_q <= '0; shf_amt_q <= '0; shf_mode_q <= '0; sel_q <= 1'b0;
      s1_valid_q <= 1'b0; s1_rw_q <= '0; s1_we_q <= 1'b0;
      s2_valid_q <= 1'b0; s2_rw_q <= '0; s2_we_q <= 1'b0;
      flags_q <= '0;
    end else begin
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      op1_q <= op1_d; op2_q <= op2_d; shf_amt_q <= shf_amt_d; shf_mode_q <= shf_mode_d; sel_q <= sel_d;
      s1_valid_q <= s1_valid_d; s1_rw_q <= s1_rw_d; s1_we_q <= s1_we_d;
      s2_valid_q <= s2_valid_d; s2_rw_q <= s2_rw_d; s2_we_q <= s2_we_d;
      flags_q <= flags_d;
    end
  end

  assign IN_READY = in_ready;
  assign A = a_q;
  assign B = b_q;
  assign C = c_q;
  assign D = d_q;
  assign OP1 = op1_q;
  assign OP2 = op2_q;
  assign SHF_AMT = shf_amt_q;
  assign SHF_MODE = shf_mode_q;
  assign SEL = sel_q;
  assign FLAGS = flags_q;
  assign WB_VALID = wb_valid;
  assign WB_ADDR = s2_rw_q;
  assign WB_DATA = FU_OUT;
endmodule
